// File: rtl/main_fsm.sv
// HUB75 1/16-scan controller for a 32x32 panel: shifts, blanks, latches and lights
// each row pair while generating the fixed crane-game frame from the scan counters.
module main_fsm #(
    parameter int unsigned COLS      = 32,
    parameter int unsigned ON_CYCLES = 64,
    parameter int unsigned CLAW_COL  = 16
) (
    input  logic       slowClk1,
    input  logic       reset,
    input  logic       en,
    output logic [3:0] row_out,
    output logic [2:0] rgb0,
    output logic [2:0] rgb1,
    output logic       clk_out,
    output logic       latch,
    output logic       oe
);

    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ON_W  = $clog2(ON_CYCLES + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SHIFT   = 3'd1;
    localparam logic [2:0] BLANK   = 3'd2;
    localparam logic [2:0] LATCH   = 3'd3;
    localparam logic [2:0] DISPLAY = 3'd4;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] CLAW     = COL_W'(CLAW_COL);
    localparam logic [ON_W-1:0]  LAST_ON  = ON_W'(ON_CYCLES - 1);

    logic [2:0]       state, state_n;
    logic [3:0]       row, row_n;
    logic [COL_W-1:0] col, col_n;
    logic             phase, phase_n;
    logic [ON_W-1:0]  on_cnt, on_cnt_n;

    logic [3:0] row_out_n;
    logic [2:0] rgb0_n, rgb1_n;
    logic       clk_out_n, latch_n, oe_n;

    // Upper half: green claw line below row 0, blue border on top row and side columns
    function automatic logic [2:0] pix_top(input logic [3:0] r, input logic [COL_W-1:0] c);
        logic [2:0] p;
        p = 3'b000;
        if (c == CLAW && r != 4'd0) begin
            p = 3'b010;
        end else if (r == 4'd0 || c == '0 || c == LAST_COL) begin
            p = 3'b001;
        end
        return p;
    endfunction

    // Lower half: red border on the bottom row and side columns
    function automatic logic [2:0] pix_bot(input logic [3:0] r, input logic [COL_W-1:0] c);
        logic [2:0] p;
        p = 3'b000;
        if (r == 4'd15 || c == '0 || c == LAST_COL) begin
            p = 3'b100;
        end
        return p;
    endfunction

    // Next-state and next-output logic; outputs are derived from the next state so
    // the registered outputs always describe the state being entered.
    always_comb begin
        state_n   = state;
        row_n     = row;
        col_n     = col;
        phase_n   = phase;
        on_cnt_n  = on_cnt;
        row_out_n = row_out;
        rgb0_n    = 3'b000;
        rgb1_n    = 3'b000;
        clk_out_n = 1'b0;
        latch_n   = 1'b0;
        oe_n      = 1'b1;

        if (state != IDLE && !en) begin
            state_n  = IDLE;
            row_n    = 4'd0;
            col_n    = '0;
            phase_n  = 1'b0;
            on_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state_n = SHIFT;
                        col_n   = '0;
                        phase_n = 1'b0;
                    end
                end
                SHIFT: begin
                    if (!phase) begin
                        phase_n = 1'b1;
                    end else if (col == LAST_COL) begin
                        state_n = BLANK;
                        phase_n = 1'b0;
                    end else begin
                        col_n   = col + COL_W'(1);
                        phase_n = 1'b0;
                    end
                end
                BLANK: begin
                    state_n = LATCH;
                end
                LATCH: begin
                    state_n  = DISPLAY;
                    on_cnt_n = '0;
                end
                DISPLAY: begin
                    if (on_cnt == LAST_ON) begin
                        state_n  = SHIFT;
                        row_n    = row + 4'd1;
                        col_n    = '0;
                        phase_n  = 1'b0;
                        on_cnt_n = '0;
                    end else begin
                        on_cnt_n = on_cnt + ON_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        case (state_n)
            SHIFT: begin
                clk_out_n = phase_n;
                rgb0_n    = pix_top(row_n, col_n);
                rgb1_n    = pix_bot(row_n, col_n);
            end
            BLANK: begin
                row_out_n = row_n;
            end
            LATCH: begin
                latch_n = 1'b1;
            end
            DISPLAY: begin
                oe_n = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge slowClk1 or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            row     <= 4'd0;
            col     <= '0;
            phase   <= 1'b0;
            on_cnt  <= '0;
            row_out <= 4'd0;
            rgb0    <= 3'b000;
            rgb1    <= 3'b000;
            clk_out <= 1'b0;
            latch   <= 1'b0;
            oe      <= 1'b1;
        end else begin
            state   <= state_n;
            row     <= row_n;
            col     <= col_n;
            phase   <= phase_n;
            on_cnt  <= on_cnt_n;
            row_out <= row_out_n;
            rgb0    <= rgb0_n;
            rgb1    <= rgb1_n;
            clk_out <= clk_out_n;
            latch   <= latch_n;
            oe      <= oe_n;
        end
    end

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: timeline model of the scan (cycle offset within a row period)
// checked every cycle, plus literal expectations for edges, latches and row order.
module tb_main_fsm;

    localparam int COLS      = 32;
    localparam int ON_CYCLES = 64;
    localparam int CLAW_COL  = 16;
    localparam int PERIOD    = 2 * COLS + 2 + ON_CYCLES;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] row_out;
    logic [2:0] rgb0, rgb1;
    logic       clk_out, latch, oe;

    always #5 clk = ~clk;

    main_fsm #(.COLS(COLS), .ON_CYCLES(ON_CYCLES), .CLAW_COL(CLAW_COL)) dut (
        .slowClk1 (clk),
        .reset    (reset),
        .en       (en),
        .row_out  (row_out),
        .rgb0     (rgb0),
        .rgb1     (rgb1),
        .clk_out  (clk_out),
        .latch    (latch),
        .oe       (oe)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: scanning is a free-running count of cycles since SHIFT began
    bit m_active;
    int m_t;
    int m_rout;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 1'b0;
            m_t      = 0;
            m_rout   = 0;
        end else if (!m_active) begin
            if (en) begin
                m_active = 1'b1;
                m_t      = 0;
            end
        end else if (!en) begin
            m_active = 1'b0;
        end else begin
            m_t++;
        end
        if (m_active && (m_t % PERIOD) == 2 * COLS) m_rout = (m_t / PERIOD) % 16;
    end

    // Capture records used by the literal checks
    logic [2:0] edge_rgb0 [0:1023];
    logic [2:0] edge_rgb1 [0:1023];
    int         edge_cyc  [0:1023];
    int         latch_cyc [0:63];
    int         latch_row [0:63];
    int         latch_pre_oe [0:63];
    int         latch_oelow  [0:63];
    int         edge_cnt  = 0;
    int         latch_cnt = 0;
    int         oe_low    = 0;
    logic       prev_clk  = 1'b0;
    logic       prev_latch = 1'b0;
    logic       prev_oe   = 1'b1;

    int         off, r, c;
    logic [2:0] e0, e1;
    logic       eclk, elat, eoe;

    always @(posedge clk) begin
        #1;
        e0 = 3'b000; e1 = 3'b000; eclk = 1'b0; elat = 1'b0; eoe = 1'b1;
        if (m_active) begin
            off = m_t % PERIOD;
            r   = (m_t / PERIOD) % 16;
            if (off < 2 * COLS) begin
                c    = off / 2;
                eclk = 1'((off % 2) == 1);
                if (c == CLAW_COL && r >= 1) e0 = 3'b010;
                else if (r == 0 || c == 0 || c == COLS - 1) e0 = 3'b001;
                if (r == 15 || c == 0 || c == COLS - 1) e1 = 3'b100;
            end else if (off == 2 * COLS + 1) begin
                elat = 1'b1;
            end else if (off > 2 * COLS + 1) begin
                eoe = 1'b0;
            end
        end
        chk("row_out", 32'(row_out), 32'(m_rout));
        chk("rgb0", 32'(rgb0), 32'(e0));
        chk("rgb1", 32'(rgb1), 32'(e1));
        chk("clk_out", 32'(clk_out), 32'(eclk));
        chk("latch", 32'(latch), 32'(elat));
        chk("oe", 32'(oe), 32'(eoe));
        chk("exclusive", 32'((32'(clk_out) + 32'(latch) + 32'(!oe)) <= 1), 32'd1);

        if (clk_out && !prev_clk && edge_cnt < 1024) begin
            edge_rgb0[edge_cnt] = rgb0;
            edge_rgb1[edge_cnt] = rgb1;
            edge_cyc[edge_cnt]  = cyc;
            edge_cnt++;
        end
        if (!oe) oe_low++;
        if (latch && !prev_latch && latch_cnt < 64) begin
            latch_cyc[latch_cnt]    = cyc;
            latch_row[latch_cnt]    = int'(row_out);
            latch_pre_oe[latch_cnt] = int'(prev_oe);
            latch_oelow[latch_cnt]  = oe_low;
            latch_cnt++;
        end
        prev_clk   = clk_out;
        prev_latch = latch;
        prev_oe    = oe;
        cyc++;
    end

    int base_e, base_l, base2_e, base2_l;

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_row_out", 32'(row_out), 32'd0);
        chk("rst_rgb0", 32'(rgb0), 32'd0);
        chk("rst_rgb1", 32'(rgb1), 32'd0);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_latch", 32'(latch), 32'd0);
        chk("rst_oe", 32'(oe), 32'd1);
        chk("rst_no_edges", 32'(edge_cnt), 32'd0);

        reset = 1'b1;
        repeat (17 * PERIOD - 10) @(negedge clk);

        chk("edges_17_rows", 32'(edge_cnt), 32'd544);
        chk("latches_17_rows", 32'(latch_cnt), 32'd17);
        for (int k = 0; k < 32; k++) begin
            chk("row0_rgb0", 32'(edge_rgb0[k]), 32'd1);
            chk("row0_rgb1", 32'(edge_rgb1[k]), (k == 0 || k == 31) ? 32'd4 : 32'd0);
            if (k < 31) chk("edge_spacing", 32'(edge_cyc[k + 1] - edge_cyc[k]), 32'd2);
        end
        chk("blank_oe", 32'(latch_pre_oe[0]), 32'd1);
        chk("blank_row0", 32'(latch_row[0]), 32'd0);
        chk("latch_period", 32'(latch_cyc[1] - latch_cyc[0]), 32'd130);
        chk("on_cycles", 32'(latch_oelow[1] - latch_oelow[0]), 32'd64);
        chk("row5_c0_rgb0", 32'(edge_rgb0[160]), 32'd1);
        chk("row5_c1_rgb0", 32'(edge_rgb0[161]), 32'd0);
        chk("row5_c16_rgb0", 32'(edge_rgb0[176]), 32'd2);
        chk("row5_c31_rgb0", 32'(edge_rgb0[191]), 32'd1);
        chk("row5_c0_rgb1", 32'(edge_rgb1[160]), 32'd4);
        chk("row5_c1_rgb1", 32'(edge_rgb1[161]), 32'd0);
        chk("row5_c16_rgb1", 32'(edge_rgb1[176]), 32'd0);
        chk("row5_c31_rgb1", 32'(edge_rgb1[191]), 32'd4);
        for (int k = 0; k < 32; k++) chk("row15_rgb1", 32'(edge_rgb1[480 + k]), 32'd4);
        for (int i = 0; i < 17; i++) chk("row_order", 32'(latch_row[i]), 32'(i % 16));

        en = 1'b0;
        @(negedge clk);
        chk("drop1_oe", 32'(oe), 32'd1);
        chk("drop1_clk_out", 32'(clk_out), 32'd0);
        chk("drop1_latch", 32'(latch), 32'd0);

        en = 1'b1;
        base_e = edge_cnt;
        base_l = latch_cnt;
        repeat (3 * PERIOD + 20) @(negedge clk);
        chk("resume_latches", 32'(latch_cnt - base_l), 32'd3);
        for (int i = 0; i < 3; i++) chk("resume_row_order", 32'(latch_row[base_l + i]), 32'(i));

        en = 1'b0;
        @(negedge clk);
        chk("drop3_oe", 32'(oe), 32'd1);
        chk("drop3_clk_out", 32'(clk_out), 32'd0);
        chk("drop3_latch", 32'(latch), 32'd0);
        chk("drop3_rgb0", 32'(rgb0), 32'd0);
        chk("drop3_rgb1", 32'(rgb1), 32'd0);
        chk("drop3_row_out_held", 32'(row_out), 32'd2);

        en = 1'b1;
        base2_e = edge_cnt;
        base2_l = latch_cnt;
        repeat (140) @(negedge clk);
        chk("restart_edges", 32'(edge_cnt - base2_e), 32'd37);
        chk("restart_latches", 32'(latch_cnt - base2_l), 32'd1);
        chk("restart_row_out", 32'(latch_row[base2_l]), 32'd0);
        for (int k = 0; k < 32; k++) chk("restart_rgb0", 32'(edge_rgb0[base2_e + k]), 32'd1);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_row_out", 32'(row_out), 32'd0);
        chk("async_rgb0", 32'(rgb0), 32'd0);
        chk("async_clk_out", 32'(clk_out), 32'd0);
        chk("async_latch", 32'(latch), 32'd0);
        chk("async_oe", 32'(oe), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Scan controller for a 32x32 HUB75 RGB LED panel with 1/16 scan, used as the display back end of the crane game.
- Drives two rows at once: physical row r from rgb0 and row r+16 from rgb1.
- Generates the fixed crane-game frame (playfield border plus claw line) internally from the row and column counters.
- Sequences pixel shift, blanking, latching and the on-time for each of the 16 row addresses continuously while enabled.

Parameters:
- COLS, 32: pixels shifted per row; must be even and at least 4.
- ON_CYCLES, 64: slowClk1 cycles the row is lit, with oe low.
- CLAW_COL, 16: column of the green claw line in the top half; must be in 1..COLS-2.

Ports:
- slowClk1  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  run enable, active-high, sampled synchronously.
- row_out  output  4  HUB75 row address A..D.
- rgb0  output  3  {R,G,B} for the upper-half pixel, physical row = row.
- rgb1  output  3  {R,G,B} for the lower-half pixel, physical row = row+16.
- clk_out  output  1  panel shift clock; the panel samples on its rising edge.
- latch  output  1  panel latch, active-high.
- oe  output  1  panel output enable, active-low (1 = blanked).

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous), all of the following apply immediately:
  - state=IDLE, row=0, col=0, phase=0, on-counter=0;
  - row_out=0, rgb0=0, rgb1=0, clk_out=0, latch=0, oe=1.
- States: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE:
  - all outputs at their reset values except row_out, which holds;
  - if en=1, go to SHIFT with col=0, phase=0.
- SHIFT:
  - two cycles per pixel.
  - phase 0: clk_out=0 and rgb0/rgb1 = pixel(row, col).
  - phase 1: clk_out=1 and rgb held, giving the panel a rising edge mid-data.
  - After phase 1 of col=COLS-1, go to BLANK. SHIFT therefore lasts exactly 2*COLS cycles.
  - oe=1 throughout SHIFT.
- BLANK (1 cycle): clk_out=0, rgb=0, oe=1, row_out<=row.
- LATCH (1 cycle): latch=1, oe=1. latch is 0 in every other state.
- DISPLAY:
  - oe=0 for exactly ON_CYCLES cycles.
  - Then row<=row+1, wrapping 15->0, and go to SHIFT with col=0.
- Row period = 2*COLS+2+ON_CYCLES cycles (130 at defaults). Frame = 16 row periods.
- Pixel function, with c = col and r = row (0..15):
  - rgb0 = 3'b010 (green) if c==CLAW_COL and r>=1;
  - else rgb0 = 3'b001 (blue) if r==0 or c==0 or c==COLS-1;
  - else rgb0 = 3'b000.
  - rgb1 = 3'b100 (red) if r==15 or c==0 or c==COLS-1;
  - else rgb1 = 3'b000.
- en=0 in any non-IDLE state: next cycle go to IDLE with oe=1, clk_out=0, latch=0 and rgb=0; row and col reset to 0. A partial shift is discarded.
- When en rises again, scanning restarts at row 0, col 0.
- reset asserted mid-operation forces the reset values immediately, regardless of clock.
- At most one of {clk_out high, latch high, oe low} is true in any cycle.

Test Plan:
- Reset: hold reset=0 for 3 cycles with en=1 -> row_out=0, rgb0=rgb1=0, clk_out=0, latch=0, oe=1. No clk_out edges occur.
- First row: release reset with en=1 -> the cycle after IDLE starts SHIFT:
  - 32 clk_out rising edges, one every 2 cycles;
  - rgb0=3'b001 at every edge (row 0 border);
  - rgb1=3'b100 at col 0 and col 31, and 3'b000 otherwise.
- Handshake order:
  - after the 64 SHIFT cycles, one BLANK cycle with row_out=0 and oe=1;
  - then one latch=1 cycle;
  - then oe=0 for exactly 64 cycles;
  - then the next SHIFT begins for row 1. The second latch pulse falls 130 cycles after the first.
- Claw/pixel check, row 5:
  - rgb0 at clock edges, cols 0, 1, 16, 31 = 001, 000, 010, 001;
  - rgb1 at the same cols = 100, 000, 000, 100.
- Wrap: run 16 rows -> row_out goes 0..15 and then back to 0. In row 15, rgb1=3'b100 at all 32 edges.
- Enable drop: drive en=0 mid-SHIFT of row 3 -> next cycle oe=1, clk_out=0, latch=0. With en=1 again, scanning resumes with a full shift of row 0; row_out changes to 0 at the next BLANK.
